// File: rtl/nibble_add_seq.sv
// nibble_add_seq: 16-bit add performed one nibble per cycle through an
// external 4-bit adder. The operands are captured on start. The result is
// published on s/cout only after all four nibbles are done, together with a
// one-cycle done pulse.
module nibble_add_seq (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] a,
  input  logic [15:0] b,
  input  logic        cin,
  output logic [3:0]  add_a,
  output logic [3:0]  add_b,
  output logic        add_cin,
  input  logic [3:0]  add_s,
  input  logic        add_cout,
  output logic        busy,
  output logic        done,
  output logic [15:0] s,
  output logic        cout
);

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  state_t      state, state_nxt;
  logic [1:0]  idx;
  logic [15:0] a_reg, b_reg, part;
  logic        carry_reg;
  logic [3:0]  bit_lo;

  // Low bit of the current nibble slice.
  assign bit_lo = {idx, 2'b00};

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next state: RUN lasts exactly four edges, and DONE lasts one cycle.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (idx == 2'd3) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs. The adder inputs are held at zero outside RUN so that the
  // external adder sees no stray activity.
  always_comb begin
    busy    = 1'b0;
    done    = 1'b0;
    add_a   = 4'h0;
    add_b   = 4'h0;
    add_cin = 1'b0;
    case (state)
      RUN: begin
        busy    = 1'b1;
        add_a   = a_reg[bit_lo +: 4];
        add_b   = b_reg[bit_lo +: 4];
        add_cin = carry_reg;
      end
      DONE:    done = 1'b1;
      default: ;
    endcase
  end

  // Datapath. The operands are captured on accept, and a partial nibble is
  // written on each RUN edge. s/cout are loaded only on the final nibble, so
  // intermediate sums never leak out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= 2'd0;
      a_reg     <= 16'h0;
      b_reg     <= 16'h0;
      part      <= 16'h0;
      carry_reg <= 1'b0;
      s         <= 16'h0;
      cout      <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          a_reg     <= a;
          b_reg     <= b;
          carry_reg <= cin;
          idx       <= 2'd0;
        end
        RUN: begin
          part[bit_lo +: 4] <= add_s;
          carry_reg         <= add_cout;
          idx               <= idx + 2'd1;
          if (idx == 2'd3) begin
            s    <= {add_s, part[11:0]};
            cout <= add_cout;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
